ftq_pd_mem_mp: RTL and testbench
================================

# ftq_pd_mem_mp

Parametrised predecode storage for the FTQ. It holds one predecode record per FTQ entry: branch mask, jump info, jump offset, JAL target and RVC mask. It offers a configurable number of synchronous read ports and write ports, per-entry valid tracking, a bulk flush, and optional same-cycle write-to-read forwarding. It is the drop-in successor to the fixed 64-entry, 2-read/1-write predecode memory, and sits between the IFU writeback path and the FTQ commit/redirect readers.

## Interface
Parameters:
- NUM_ENTRIES, default 64: entry count; must be a power of 2 and at least 4. AW = log2(NUM_ENTRIES).
- NUM_READ, default 2: number of read ports, 1–4.
- NUM_WRITE, default 1: number of write ports, 1–2.
- PREDICT_WIDTH, default 16: number of slots per fetch block. Sets the brMask/rvcMask width; jmpOffset width OW = log2(PREDICT_WIDTH).
- VADDR_BITS, default 50: jalTarget width.
- DW: derived record width, 2*PREDICT_WIDTH + 4 + OW + VADDR_BITS (90 at defaults).
- Record packing, MSB to LSB: brMask, jmpInfo_valid, jmpInfo_bits[2:0], jmpOffset, jalTarget, rvcMask.

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high.
- io_ren, in, NUM_READ: per-port read enable.
- io_raddr, in, NUM_READ*AW: flattened read addresses; port i is at [i*AW +: AW].
- io_rdata, out, NUM_READ*DW: flattened read records, registered.
- io_rvalid, out, NUM_READ: registered valid bit of the entry that was read.
- io_wen, in, NUM_WRITE: per-port write enable.
- io_waddr, in, NUM_WRITE*AW: flattened write addresses.
- io_wdata, in, NUM_WRITE*DW: flattened write records.
- io_flush, in, 1: clears every entry's valid bit.

## Operation
- Storage: an NUM_ENTRIES×DW data array plus an NUM_ENTRIES valid-bit vector. The data array is not reset; the valid vector is.
- Write: io_wen[j]=1 writes io_wdata[j] to entry io_waddr[j] and sets that entry's valid bit.
- Write collision: if two ports write the same address in one cycle, the higher port index wins for both data and valid.
- Flush:
  - io_flush=1 clears all valid bits at the edge.
  - A write in the same cycle as a flush still lands and leaves its entry valid (write beats flush).
- Read:
  - io_ren[i]=1 captures entry io_raddr[i] into the port-i output registers.
  - io_rvalid[i] gets the entry's valid bit.
  - io_rdata[i] gets the entry's data when the entry is valid, and all zeros when it is not.
- Hold: io_ren[i]=0 leaves io_rdata[i] and io_rvalid[i] unchanged, including across later writes to the previously read address.
- Read ports are fully independent. Several ports may read the same address in one cycle.
- Address range: addresses are AW wide, so every address is in range. Wrap-around is the caller's concern.

## Timing
- Read latency: 1 cycle. An address presented at edge t produces data valid after edge t.
- Write latency: 1 cycle. Data written at edge t is visible to a read issued at edge t+1.
- Read and write to the same address at the same edge: see Configuration.
- Flush and read at the same edge: the read sees pre-flush valid state, unless the bypass feature forwards a write. The next read of that entry returns rvalid=0.
- Reset at any time, including mid-traffic, takes effect at the next edge:
  - io_rdata = 0 and io_rvalid = 0 on every port.
  - All valid bits cleared.
  - Writes and reads asserted in the reset cycle are ignored.
- No backpressure and no handshake; every request completes in one cycle.

## Configuration
- FTQ_PD_MEM_BYPASS_EN defined:
  - A read whose address matches an active write at the same edge returns that write's io_wdata with rvalid=1.
  - Among several matching write ports, the highest index is forwarded.
  - Forwarding also applies when io_flush is asserted in the same cycle.
- FTQ_PD_MEM_BYPASS_EN undefined:
  - Read-before-write: a same-edge read returns the old entry contents and old valid bit.
  - The new data is seen from edge t+1.

## Test plan
- Reset, then read addresses 0 and 63 on both ports:
  - Both ports return rvalid=0 and rdata=0.
  - All outputs are 0 in the cycle after reset.
- Write address 5 with brMask=0x8001, jmpOffset=3, jalTarget=0x3_FFFF_0000_1234, then read address 5 the next cycle on ports 0 and 1:
  - Both ports return the identical record with rvalid=1.
- Write address 9 = A and read address 9 at the same edge (old value B valid):
  - With FTQ_PD_MEM_BYPASS_EN: returns A.
  - Without it: returns B, then A on a read one cycle later.
- NUM_WRITE=2, both ports write address 12 (port0 = 0x1…, port1 = 0x2…):
  - A following read returns the port-1 record.
- Flush with a simultaneous write to address 7:
  - The next reads return rvalid=1 for address 7 and rvalid=0 with rdata=0 for address 6 (previously valid).
- Read address 3, then drop io_ren for 4 cycles while overwriting address 3:
  - io_rdata holds the original value throughout.
  - Assert reset mid-sequence: outputs are 0 after the next edge.

Source files
------------

// File: rtl/ftq_pd_mem_mp.sv
// Predecode record storage for the FTQ: NUM_READ registered read ports, NUM_WRITE write ports,
// per-entry valid bits and bulk flush. Define FTQ_PD_MEM_BYPASS_EN for same-edge write-to-read forwarding.
module ftq_pd_mem_mp #(
  parameter int NUM_ENTRIES   = 64,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 1,
  parameter int PREDICT_WIDTH = 16,
  parameter int VADDR_BITS    = 50,
  localparam int AW = $clog2(NUM_ENTRIES),
  localparam int OW = $clog2(PREDICT_WIDTH),
  localparam int DW = 2*PREDICT_WIDTH + 4 + OW + VADDR_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_READ-1:0]     io_ren,
  input  logic [NUM_READ*AW-1:0]  io_raddr,
  output logic [NUM_READ*DW-1:0]  io_rdata,
  output logic [NUM_READ-1:0]     io_rvalid,
  input  logic [NUM_WRITE-1:0]    io_wen,
  input  logic [NUM_WRITE*AW-1:0] io_waddr,
  input  logic [NUM_WRITE*DW-1:0] io_wdata,
  input  logic                    io_flush
);

  logic [DW-1:0]          mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] validQ;
  logic [NUM_ENTRIES-1:0] validNext;

  logic [AW-1:0]          rdAddr [NUM_READ];
  logic [DW-1:0]          rdData [NUM_READ];
  logic [NUM_READ-1:0]    rdValid;

  // Writes are applied after the flush so a same-cycle write leaves its entry valid;
  // ascending port order lets the highest index win on a collision.
  always_comb begin
    validNext = validQ;
    if (io_flush) validNext = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (io_wen[j]) validNext[io_waddr[j*AW +: AW]] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) validQ <= '0;
    else       validQ <= validNext;
  end

  // Data array is intentionally not reset; the valid vector masks stale contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (io_wen[j]) mem[io_waddr[j*AW +: AW]] <= io_wdata[j*DW +: DW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rdAddr[i]  = io_raddr[i*AW +: AW];
      rdData[i]  = mem[rdAddr[i]];
      rdValid[i] = validQ[rdAddr[i]];
`ifdef FTQ_PD_MEM_BYPASS_EN
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (io_wen[j] && (io_waddr[j*AW +: AW] == rdAddr[i])) begin
          rdData[i]  = io_wdata[j*DW +: DW];
          rdValid[i] = 1'b1;
        end
      end
`endif
    end
  end

  // Invalid entries read back as zero; disabled ports hold their last capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_rdata  <= '0;
      io_rvalid <= '0;
    end else begin
      for (int i = 0; i < NUM_READ; i++) begin
        if (io_ren[i]) begin
          io_rdata[i*DW +: DW] <= rdValid[i] ? rdData[i] : '0;
          io_rvalid[i]         <= rdValid[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ftq_pd_mem_mp.sv
// Bench for ftq_pd_mem_mp with 64 entries, 2 read ports and 2 write ports; a reference model
// pushes the expected {rvalid, rdata} of every port each cycle and the outputs are compared after the edge.
module tb_ftq_pd_mem_mp;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 6;
  localparam int DW = 90;

  logic               clock = 1'b0;
  logic               reset;
  logic [NR-1:0]      ren;
  logic [NR*AW-1:0]   raddr;
  logic [NR*DW-1:0]   rdata;
  logic [NR-1:0]      rvalid;
  logic [NW-1:0]      wen;
  logic [NW*AW-1:0]   waddr;
  logic [NW*DW-1:0]   wdata;
  logic               flush;

  int checks = 0;
  int errors = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem [64];
  logic [63:0]   model_valid;
  logic [DW:0]   model_hold [NR];

  ftq_pd_mem_mp #(.NUM_ENTRIES(64), .NUM_READ(NR), .NUM_WRITE(NW),
                  .PREDICT_WIDTH(16), .VADDR_BITS(50)) dut (
    .clock(clock), .reset(reset),
    .io_ren(ren), .io_raddr(raddr), .io_rdata(rdata), .io_rvalid(rvalid),
    .io_wen(wen), .io_waddr(waddr), .io_wdata(wdata), .io_flush(flush)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_rec(input logic [15:0] br, input logic jv, input logic [2:0] jb,
                                           input logic [3:0] off, input logic [49:0] jal, input logic [15:0] rvc);
    return {br, jv, jb, off, jal, rvc};
  endfunction

  // driver tasks
  task automatic clear_inputs();
    reset = 1'b0; ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0; flush = 1'b0;
  endtask

  task automatic set_read(input int p, input logic [AW-1:0] a);
    ren[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  task automatic set_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  // Model the edge, push expectations, clock, then score both ports.
  task automatic step();
    logic [AW-1:0] a;
    logic          v;
    logic [DW-1:0] d;
    if (reset) begin
      for (int i = 0; i < NR; i++) model_hold[i] = '0;
      model_valid = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (ren[i]) begin
          a = raddr[i*AW +: AW];
          v = model_valid[a];
          d = model_mem[a];
`ifdef FTQ_PD_MEM_BYPASS_EN
          for (int j = 0; j < NW; j++)
            if (wen[j] && waddr[j*AW +: AW] == a) begin v = 1'b1; d = wdata[j*DW +: DW]; end
`endif
          model_hold[i] = v ? {1'b1, d} : '0;
        end
      end
      if (flush) model_valid = '0;
      for (int j = 0; j < NW; j++)
        if (wen[j]) begin
          model_mem[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
          model_valid[waddr[j*AW +: AW]] = 1'b1;
        end
    end
    for (int i = 0; i < NR; i++) exp_q.push_back(model_hold[i]);
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      logic [DW:0] e;
      e = exp_q.pop_front();
      check($sformatf("port%0d", i), {rvalid[i], rdata[i*DW +: DW]}, e);
    end
    clear_inputs();
  endtask

  initial begin
    logic [DW-1:0] rec5, rec_a, rec_b, rec12a, rec12b, rec3, rec6, rec7;
    model_valid = '0;
    for (int i = 0; i < NR; i++) model_hold[i] = '0;
    clear_inputs();
    rec5   = mk_rec(16'h8001, 1'b1, 3'b010, 4'd3, 50'h3_FFFF_0000_1234, 16'h00F0);
    rec_a  = mk_rec(16'hAAAA, 1'b0, 3'b001, 4'd9, 50'h0_0000_0000_0A0A, 16'h5555);
    rec_b  = mk_rec(16'hBBBB, 1'b1, 3'b111, 4'd1, 50'h1_2345_6789_ABCD, 16'h0F0F);
    rec12a = {4'h1, 86'h0_1111_2222_3333_4444_5555};
    rec12b = {4'h2, 86'h0_6666_7777_8888_9999_AAAA};
    rec3   = mk_rec(16'h0003, 1'b1, 3'b100, 4'd15, 50'h2_0000_0000_0003, 16'hFFFF);
    rec6   = mk_rec(16'h0606, 1'b0, 3'b000, 4'd6, 50'h0_0000_0000_0006, 16'h0006);
    rec7   = mk_rec(16'h0707, 1'b1, 3'b011, 4'd7, 50'h0_0000_0000_0007, 16'h0007);

    reset = 1'b1; step();
    check("reset_rvalid", rvalid, 2'b00);
    check("reset_rdata", rdata, '0);
    set_read(0, 6'd0); set_read(1, 6'd63); step();
    set_read(0, 6'd63); set_read(1, 6'd0); step();
    check("empty_rvalid", rvalid, 2'b00);

    set_write(0, 6'd5, rec5); step();
    set_read(0, 6'd5); set_read(1, 6'd5); step();
    check("rec5_p0", {rvalid[0], rdata[0 +: DW]}, {1'b1, rec5});
    check("rec5_p1", {rvalid[1], rdata[DW +: DW]}, {1'b1, rec5});

    set_write(0, 6'd9, rec_b); step();
    set_write(0, 6'd9, rec_a); set_read(0, 6'd9); step();
`ifdef FTQ_PD_MEM_BYPASS_EN
    check("same_edge_rw", rdata[0 +: DW], rec_a);
`else
    check("same_edge_rw", rdata[0 +: DW], rec_b);
`endif
    set_read(0, 6'd9); step();
    check("after_rw", rdata[0 +: DW], rec_a);

    set_write(0, 6'd12, rec12a); set_write(1, 6'd12, rec12b); step();
    set_read(1, 6'd12); step();
    check("wr_collision", rdata[DW +: DW], rec12b);

    set_write(0, 6'd6, rec6); step();
    flush = 1'b1; set_write(1, 6'd7, rec7); step();
    set_read(0, 6'd7); set_read(1, 6'd6); step();
    check("flush_wr_valid", rvalid[0], 1'b1);
    check("flush_wr_data", rdata[0 +: DW], rec7);
    check("flushed_valid", rvalid[1], 1'b0);
    check("flushed_data", rdata[DW +: DW], '0);

    set_write(0, 6'd3, rec3); step();
    set_read(0, 6'd3); step();
    for (int k = 0; k < 4; k++) begin
      set_write(0, 6'd3, rec_a ^ DW'(k)); step();
      check("hold_rdata", rdata[0 +: DW], rec3);
    end
    reset = 1'b1; set_read(0, 6'd3); set_write(0, 6'd3, rec_b); step();
    check("midreset_rdata", rdata, '0);
    check("midreset_rvalid", rvalid, 2'b00);
    set_read(0, 6'd3); step();
    check("post_reset_valid", rvalid[0], 1'b0);

    // Random traffic over a small address window to force collisions and hits.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NR; p++)
        if ($urandom_range(0, 2) != 0) set_read(p, 6'($urandom_range(0, 11)));
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 1) != 0)
          set_write(p, 6'($urandom_range(0, 11)), {26'($urandom), $urandom, $urandom});
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
